// File: rtl/wb_sequencer.sv
// Register-writeback sequencer: walks the writeback phase of a decoded
// instruction, driving RegDest/WbSrc/RegWrite, with memory-wait timeout.
module wb_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rs_idx,
    input  logic [4:0] rt_idx,
    input  logic [4:0] rd_idx,
    input  logic       mem_ready,
    output logic [2:0] RegDest,
    output logic [2:0] WbSrc,
    output logic       RegWrite,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);

    typedef enum logic [2:0] {IDLE, WAIT_MEM, WR1, WR2, DONE} state_t;
    typedef enum logic [2:0] {
        C_RALU, C_IALU, C_LW, C_JAL, C_PUSH, C_POP, C_NOWR, C_ILL
    } cls_t;

    state_t     state, state_n;
    cls_t       cls, cls_in;
    logic [4:0] rs_q, rt_q, rd_q;
    logic [7:0] cnt;
    logic [1:0] err_q, err_n;
    logic [4:0] sel_idx;
    logic       sel_checked;

    always_comb begin
        cls_in = C_ILL;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h05:   cls_in = C_PUSH;
                    6'h06:   cls_in = C_POP;
                    6'h08:   cls_in = C_NOWR;
                    default: cls_in = C_RALU;
                endcase
            end
            6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0f: cls_in = C_IALU;
            6'h23:                             cls_in = C_LW;
            6'h03:                             cls_in = C_JAL;
            6'h2b, 6'h04, 6'h05, 6'h02:        cls_in = C_NOWR;
            default:                           cls_in = C_ILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cls   <= C_ILL;
            rs_q  <= '0;
            rt_q  <= '0;
            rd_q  <= '0;
            cnt   <= '0;
            err_q <= '0;
        end else begin
            state <= state_n;
            err_q <= err_n;
            // counter idles at zero outside WAIT_MEM, so entry always starts clean
            cnt   <= (state == WAIT_MEM && !mem_ready) ? cnt + 8'd1 : '0;
            if (state == IDLE && start) begin
                cls  <= cls_in;
                rs_q <= rs_idx;
                rt_q <= rt_idx;
                rd_q <= rd_idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        err_n   = err_q;
        case (state)
            IDLE: begin
                if (start) begin
                    err_n = 2'b00;
                    case (cls_in)
                        C_LW, C_POP: state_n = WAIT_MEM;
                        C_NOWR:      state_n = DONE;
                        C_ILL: begin
                            state_n = DONE;
                            err_n   = 2'b01;
                        end
                        default:     state_n = WR1;
                    endcase
                end
            end
            WAIT_MEM: begin
                if (mem_ready) begin
                    state_n = WR1;
                end else if (cnt == 8'(MEM_TIMEOUT - 1)) begin
                    state_n = DONE;
                    err_n   = 2'b10;
                end
            end
            WR1:     state_n = (cls == C_POP) ? WR2 : DONE;
            WR2:     state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        RegDest = 3'b000;
        WbSrc   = 3'b000;
        if (state == WR1) begin
            case (cls)
                C_RALU:  begin RegDest = 3'b100; WbSrc = 3'b000; end
                C_IALU:  begin RegDest = 3'b000; WbSrc = 3'b000; end
                C_LW:    begin RegDest = 3'b000; WbSrc = 3'b001; end
                C_JAL:   begin RegDest = 3'b011; WbSrc = 3'b010; end
                C_PUSH:  begin RegDest = 3'b010; WbSrc = 3'b011; end
                C_POP:   begin RegDest = 3'b001; WbSrc = 3'b001; end
                default: begin RegDest = 3'b000; WbSrc = 3'b000; end
            endcase
        end else if (state == WR2) begin
            RegDest = 3'b010;
            WbSrc   = 3'b100;
        end
    end

    // sp/ra selects are fixed non-zero registers and never suppressed
    always_comb begin
        sel_idx     = '0;
        sel_checked = 1'b1;
        case (RegDest)
            3'b000:  sel_idx = rt_q;
            3'b001:  sel_idx = rs_q;
            3'b100:  sel_idx = rd_q;
            default: sel_checked = 1'b0;
        endcase
    end

    assign RegWrite = (state == WR1 || state == WR2) && (!sel_checked || sel_idx != 5'd0);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign err      = (state == DONE) ? err_q : 2'b00;

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Register-writeback sequencer for the multicycle CPU. It takes a decoded instruction on a one-cycle start pulse and walks the writeback phase. Along the way it drives the 3-bit RegDest select of the register-destination mux, the write-data source select WbSrc, and RegWrite. It also handles multi-write instructions (pop), memory-wait with timeout, and illegal-opcode reporting. It sits between the main control FSM and the register bank.

## Interface
- MEM_TIMEOUT, 15: maximum cycles spent waiting for mem_ready (legal 1..255).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- opcode  in  6  instruction opcode, sampled with start.
- funct  in  6  instruction funct, sampled with start.
- rs_idx, rt_idx, rd_idx  in  5 each  register indices, sampled with start.
- mem_ready  in  1  memory read data valid.
- RegDest  out  3  destination select: 000 rt, 001 rs, 010 reg 29 (sp), 011 reg 31 (ra), 100 rd.
- WbSrc  out  3  write-data select: 000 ALU, 001 MEM, 010 PC, 011 SP_DEC (sp-4), 100 SP_INC (sp+4).
- RegWrite  out  1  register bank write enable.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  2  valid only with done: 00 ok, 01 illegal instruction, 10 memory timeout.

## Operation
- States: IDLE, WAIT_MEM, WR1, WR2, DONE.
- All outputs are Moore: they depend only on the state, the latched instruction class and the latched indices.
- IDLE with start=1: latch opcode, funct and the indices; classify the instruction; branch as follows.
  - R-type ALU (opcode 0x00, funct not 0x05/0x06/0x08) -> WR1; WR1 drives RegDest=100, WbSrc=000.
  - I-type ALU (opcode 0x08, 0x09, 0x0a, 0x0c, 0x0f) -> WR1; WR1 drives RegDest=000, WbSrc=000.
  - lw (0x23) -> WAIT_MEM; WR1 drives RegDest=000, WbSrc=001.
  - jal (0x03) -> WR1; WR1 drives RegDest=011, WbSrc=010.
  - push (opcode 0x00, funct 0x05) -> WR1; WR1 drives RegDest=010, WbSrc=011.
  - pop (opcode 0x00, funct 0x06) -> WAIT_MEM.
    - WR1 drives RegDest=001, WbSrc=001.
    - WR2 drives RegDest=010, WbSrc=100.
  - No-write instructions -> DONE, err=00: jr (opcode 0x00, funct 0x08), sw (0x2b), beq (0x04), bne (0x05), j (0x02).
  - Anything else -> DONE, err=01.
- WAIT_MEM:
  - The 8-bit wait counter is cleared on entry and increments each cycle mem_ready=0.
  - mem_ready=1 -> WR1.
  - mem_ready=0 with counter = MEM_TIMEOUT-1 -> DONE, err=10, no write.
  - mem_ready=1 on the final allowed cycle wins over the timeout.
- WR1 -> WR2 for pop, otherwise -> DONE. WR2 -> DONE.
- RegWrite is 1 in WR1/WR2 and 0 in every other state.
- Zero-register suppression: RegWrite is forced to 0 when the selected index is 0. The selected index is rt_idx, rs_idx or rd_idx for selects 000/001/100. Selects 010 and 011 always write. State sequencing is unchanged by suppression.
- DONE: done=1 for one cycle, err holds the result, then -> IDLE.
- start outside IDLE is ignored and not queued.
- RegDest and WbSrc are 000 outside WR1/WR2.

## Timing
- Reset (async, rst_n=0): state=IDLE and counter=0 immediately. Outputs: RegDest=000, WbSrc=000, RegWrite=0, busy=0, done=0, err=00.
- Reset asserted mid-sequence aborts it. No write or done occurs after release; the first valid start is in the first cycle after rst_n rises.
- Single-write op, start sampled at edge 0: WR1 during cycle 1 (RegWrite=1), DONE during cycle 2, IDLE in cycle 3. busy is high in cycles 1-2.
- No-write/illegal op: DONE during cycle 1, IDLE in cycle 2.
- lw: WAIT_MEM from cycle 1; mem_ready sampled high at edge k -> WR1 in cycle k+1, DONE in k+2.
- pop: WR1 and WR2 in consecutive cycles after WAIT_MEM exits, then DONE.
- Timeout: WAIT_MEM lasts exactly MEM_TIMEOUT cycles, then DONE with err=10.
- A new start is accepted in the cycle after DONE, giving a minimum of 3 cycles per single-write instruction.

## Test plan
- Reset and R-type:
  - rst_n low -> all outputs 0.
  - start, opcode 0x00, funct 0x20, rd_idx=8 -> cycle 1: RegDest=100, WbSrc=000, RegWrite=1; cycle 2: done=1, err=00.
- jal then push back-to-back:
  - jal: RegDest=011, WbSrc=010, RegWrite=1.
  - push (start in the cycle after done): RegDest=010, WbSrc=011, RegWrite=1.
  - A start pulse issued while busy is ignored.
- pop, rs_idx=9, mem_ready after 3 wait cycles:
  - WAIT_MEM 3 cycles, then WR1 (RegDest=001, WbSrc=001, RegWrite=1), then WR2 (RegDest=010, WbSrc=100, RegWrite=1).
  - done=1 in the next cycle.
- lw timeout with MEM_TIMEOUT=4 and mem_ready held 0:
  - 4 WAIT_MEM cycles, then done=1, err=10, RegWrite never asserted.
  - Repeat with mem_ready=1 on the 4th wait cycle -> normal write, err=00.
- Zero-register and illegal:
  - addi with rt_idx=0 -> WR1 with RegWrite=0, done with err=00.
  - opcode 0x3f -> done in cycle 1, err=01.
- Reset mid-op: assert rst_n=0 during WR1 of pop -> RegWrite drops immediately; no WR2 and no done after release.
